dircc_packet_tx: RTL and testbench
==================================

# dircc_packet_tx

Packet injector for the DiRCC mesh. It accepts a send command (destination address, payload length, final-word empty count) plus a stream of 32-bit payload words from the local core. It frames them as an Avalon-ST packet (destination header, source/length header, payload) and drives the router's `here` input port.

## Interface
- `LEN_W`, default 16: width of the payload length field, in words; max 16.
- `clk_clk`, in, 1: system clock.
- `reset_reset_n`, in, 1: synchronous, active-low reset.
- `address_address`, in, 32: this node's address; `[15:0]` is embedded in header word 1.
- `cmd_valid`, in, 1: a send command is presented.
- `cmd_ready`, out, 1: the command is accepted when `cmd_valid && cmd_ready`.
- `cmd_dest`, in, 32: destination address.
- `cmd_len`, in, LEN_W: number of payload words; 0 is legal.
- `cmd_empty`, in, 2: empty-symbol count applied to the final beat.
- `payload_data`, in, 32: payload word.
- `payload_valid`, in, 1: payload word is presented.
- `payload_ready`, out, 1: a payload word is consumed when `payload_valid && payload_ready`.
- `output_here_data`, out, 32: Avalon-ST data to the router.
- `output_here_valid`, out, 1: Avalon-ST valid.
- `output_here_ready`, in, 1: Avalon-ST ready, ready latency 0.
- `output_here_startofpacket`, out, 1: Avalon-ST start of packet.
- `output_here_endofpacket`, out, 1: Avalon-ST end of packet.
- `output_here_empty`, out, 2: Avalon-ST empty.
- `tx_pkt_count`, out, 32: count of packets sent; present only with `DIRCC_TX_PKT_COUNT_EN`.

## Operation
- **Output register.** All `output_here_*` signals come from a single output register stage. It loads only when free, where free = `!output_here_valid || output_here_ready`. When it is valid and `output_here_ready` is low, all outputs hold stable.
- **FSM states:** IDLE, HDR_SRC, PAYLOAD.
- **IDLE**
  - `cmd_ready = reset_reset_n && free`.
  - On command accept, the register loads: data = `cmd_dest`, sop = 1, eop = 0, empty = 0.
  - The block latches `cmd_len` into `remaining` and `cmd_empty` into `last_empty`, then moves to HDR_SRC.
- **HDR_SRC**
  - When free, the register loads: data = `{address_address[15:0], 16'(len)}`, where the length is zero-extended.
  - sop = 0.
  - If `remaining == 0`: eop = 1, empty = `last_empty`, next state IDLE.
  - Otherwise: eop = 0, next state PAYLOAD.
- **PAYLOAD**
  - `payload_ready = free`; the signal is combinational.
  - On payload accept, the register loads `payload_data` and `remaining` decrements.
  - When `remaining == 1` at the accept: eop = 1, empty = `last_empty`, next state IDLE.
  - If `payload_valid` is low while the register is free, `output_here_valid` falls to 0 (a bubble); the packet is not aborted.
- `payload_ready` is 0 outside PAYLOAD. `cmd_ready` is 0 outside IDLE.
- `empty` is 0 on every non-final beat.
- **Reset**, synchronous and taking effect at any time including mid-packet:
  - The FSM returns to IDLE and `remaining` is cleared.
  - `output_here_valid`, `output_here_startofpacket`, `output_here_endofpacket` are cleared to 0.
  - `output_here_data` and `output_here_empty` are cleared to 0.
  - `tx_pkt_count` is cleared to 0.
  - A partially sent packet is abandoned; the router is reset together with this block.

## Timing
- Command accepted at cycle t → destination beat valid at t+1 with sop.
- Source/length beat is valid at t+2 if the destination beat is accepted at t+1.
- Sustained throughput is 1 beat/cycle with `output_here_ready` and `payload_valid` held high. A packet of N payload words occupies N+2 beats.
- Back-to-back packets: the eop beat is loaded at cycle t and the FSM is in IDLE at t+1. The next command can be accepted at t+1 if the register is free, so the next sop is valid at t+2. There are no idle beats between packets on the output.
- Latency from payload accept to output valid is exactly 1 cycle.
- Backpressure: `payload_ready` and `cmd_ready` fall in the same cycle that `output_here_valid && !output_here_ready`.

## Configuration
- **`DIRCC_TX_PKT_COUNT_EN` defined:**
  - `tx_pkt_count` port exists.
  - It increments by 1 on each cycle where `output_here_valid && output_here_ready && output_here_endofpacket`.
  - It wraps from 0xFFFFFFFF to 0.
- **Not defined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Zero-length packet.** Reset, `address_address` = 0x00000005, then command with dest = 0x00000012, len = 0, empty = 0, ready held high. Required: 2 beats, 0x00000012 (sop) then 0x00050000 (eop, empty 0); `cmd_ready` high again the cycle after the eop beat loads.
- **Three-word payload, no backpressure.** Command with len = 3, empty = 2 and payload 0xA, 0xB, 0xC, ready held high. Required: 5 consecutive beats, with the final beat 0xC carrying eop and empty = 2.
- **Backpressure.** `output_here_ready` held low for 4 cycles during the second payload beat. Required: data/sop/eop stable across the stall, `payload_ready` = 0, no word lost or duplicated.
- **Payload starvation.** `payload_valid` dropped for 2 cycles mid-packet. Required: `output_here_valid` = 0 for 2 cycles, packet resumes, eop count unchanged.
- **Back-to-back packets.** Two commands (len 1 and len 2) presented continuously with ready held high. Required: 7 consecutive valid beats; sop of packet 2 immediately follows eop of packet 1. With the macro defined, `tx_pkt_count` = 2.
- **Reset mid-packet.** `reset_reset_n` low for 1 cycle during payload. Required: next cycle `output_here_valid` = 0, `cmd_ready` = 1, `tx_pkt_count` = 0; a subsequent len = 1 packet is framed correctly.

Source files
------------

// File: rtl/dircc_packet_tx.sv
// dircc_packet_tx: frames a send command plus its payload words into an Avalon-ST packet
// (destination header, source/length header, payload) for the router's local input port.
// Optional feature macro: DIRCC_TX_PKT_COUNT_EN adds the tx_pkt_count sent-packet counter.
module dircc_packet_tx #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [31:0]      address_address,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_dest,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [1:0]       cmd_empty,
  input  logic [31:0]      payload_data,
  input  logic             payload_valid,
  output logic             payload_ready,
  output logic [31:0]      output_here_data,
  output logic             output_here_valid,
  input  logic             output_here_ready,
  output logic             output_here_startofpacket,
  output logic             output_here_endofpacket,
  output logic [1:0]       output_here_empty
`ifdef DIRCC_TX_PKT_COUNT_EN
  ,
  output logic [31:0]      tx_pkt_count
`endif
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHdrSrc  = 2'd1,
    StPayload = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [1:0]       last_empty_q, last_empty_d;

  // Output register stage: every output_here_* bit comes straight from these flops.
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [1:0]  empty_q, empty_d;

  logic        free;
  logic        cmd_fire;
  logic        pay_fire;
  logic [15:0] hdr_len;

  // Only the low half of the node address goes into the source header.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address_address[31:16];

  // The register may load a new beat when it is empty or its current beat is being taken.
  assign free    = !valid_q || output_here_ready;
  assign hdr_len = 16'(remaining_q);

  // Next-state, handshake and output-register load decode.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    last_empty_d  = last_empty_q;
    // A free register with nothing new to load becomes a bubble; a stalled one holds.
    valid_d       = free ? 1'b0 : valid_q;
    data_d        = data_q;
    sop_d         = sop_q;
    eop_d         = eop_q;
    empty_d       = empty_q;
    cmd_ready     = 1'b0;
    payload_ready = 1'b0;
    cmd_fire      = 1'b0;
    pay_fire      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = reset_reset_n && free;
        cmd_fire  = cmd_valid && reset_reset_n && free;
        if (cmd_fire) begin
          valid_d      = 1'b1;
          data_d       = cmd_dest;
          sop_d        = 1'b1;
          eop_d        = 1'b0;
          empty_d      = 2'd0;
          remaining_d  = cmd_len;
          last_empty_d = cmd_empty;
          state_d      = StHdrSrc;
        end
      end

      StHdrSrc: begin
        if (free) begin
          valid_d = 1'b1;
          data_d  = {address_address[15:0], hdr_len};
          sop_d   = 1'b0;
          if (remaining_q == '0) begin
            // Zero-length packet: the header is also the final beat.
            eop_d   = 1'b1;
            empty_d = last_empty_q;
            state_d = StIdle;
          end else begin
            eop_d   = 1'b0;
            empty_d = 2'd0;
            state_d = StPayload;
          end
        end
      end

      StPayload: begin
        payload_ready = free;
        pay_fire      = payload_valid && free;
        if (pay_fire) begin
          valid_d     = 1'b1;
          data_d      = payload_data;
          sop_d       = 1'b0;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            eop_d   = 1'b1;
            empty_d = last_empty_q;
            state_d = StIdle;
          end else begin
            eop_d   = 1'b0;
            empty_d = 2'd0;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output register; reset abandons any packet in flight.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      last_empty_q <= 2'd0;
      valid_q      <= 1'b0;
      data_q       <= 32'd0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      empty_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      last_empty_q <= last_empty_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      empty_q      <= empty_d;
    end
  end

  assign output_here_valid         = valid_q;
  assign output_here_data          = data_q;
  assign output_here_startofpacket = sop_q;
  assign output_here_endofpacket   = eop_q;
  assign output_here_empty         = empty_q;

`ifdef DIRCC_TX_PKT_COUNT_EN
  logic [31:0] pkt_count_q, pkt_count_d;

  // Count final beats as they leave; wraps naturally at 2^32.
  always_comb begin
    pkt_count_d = pkt_count_q;
    if (valid_q && output_here_ready && eop_q) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
  end

  // Sent-packet counter register.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      pkt_count_q <= 32'd0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign tx_pkt_count = pkt_count_q;
`else
  // Counter not built.
`endif

endmodule

// File: tb/tb_dircc_packet_tx.sv
// Self-checking bench for dircc_packet_tx: directed scenarios plus randomized packets
// compared against a packet-level reference model.
module tb_dircc_packet_tx;
  localparam int unsigned LEN_W = 16;

  typedef logic [35:0] beat_t;  // {data, sop, eop, empty}

  logic             clk_clk = 1'b0;
  logic             reset_reset_n;
  logic [31:0]      address_address;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_dest;
  logic [LEN_W-1:0] cmd_len;
  logic [1:0]       cmd_empty;
  logic [31:0]      payload_data;
  logic             payload_valid;
  logic             payload_ready;
  logic [31:0]      output_here_data;
  logic             output_here_valid;
  logic             output_here_ready;
  logic             output_here_startofpacket;
  logic             output_here_endofpacket;
  logic [1:0]       output_here_empty;
`ifdef DIRCC_TX_PKT_COUNT_EN
  logic [31:0]      tx_pkt_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int eops  = 0;

  beat_t       exp_q[$];
  beat_t       got_q[$];
  int          got_cyc[$];
  logic [31:0] pl[64];

  always #5 clk_clk = ~clk_clk;

  dircc_packet_tx #(.LEN_W(LEN_W)) dut (
    .clk_clk                  (clk_clk),
    .reset_reset_n            (reset_reset_n),
    .address_address          (address_address),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_dest                 (cmd_dest),
    .cmd_len                  (cmd_len),
    .cmd_empty                (cmd_empty),
    .payload_data             (payload_data),
    .payload_valid            (payload_valid),
    .payload_ready            (payload_ready),
    .output_here_data         (output_here_data),
    .output_here_valid        (output_here_valid),
    .output_here_ready        (output_here_ready),
    .output_here_startofpacket(output_here_startofpacket),
    .output_here_endofpacket  (output_here_endofpacket),
    .output_here_empty        (output_here_empty)
`ifdef DIRCC_TX_PKT_COUNT_EN
    ,
    .tx_pkt_count             (tx_pkt_count)
`endif
  );

  function automatic beat_t mk(input logic [31:0] d, input logic s, input logic e,
                               input logic [1:0] m);
    return {d, s, e, m};
  endfunction

  // Record every beat the router accepts, with its cycle number.
  always @(posedge clk_clk) begin
    cyc <= cyc + 1;
    if (output_here_valid && output_here_ready) begin
      got_q.push_back(mk(output_here_data, output_here_startofpacket,
                         output_here_endofpacket, output_here_empty));
      got_cyc.push_back(cyc);
    end
    if (!reset_reset_n) eops <= 0;
    else if (output_here_valid && output_here_ready && output_here_endofpacket) eops <= eops + 1;
  end

  // Reference framing: dest header, source/length header, then len payload words.
  function automatic void model_pkt(input logic [31:0] dest, input int len,
                                    input logic [1:0] emp);
    logic [31:0] hdr;
    hdr = {address_address[15:0], 16'(len)};
    exp_q.push_back(mk(dest, 1'b1, 1'b0, 2'd0));
    exp_q.push_back(mk(hdr, 1'b0, len == 0, (len == 0) ? emp : 2'd0));
    for (int k = 0; k < len; k++)
      exp_q.push_back(mk(pl[k], 1'b0, k == len - 1, (k == len - 1) ? emp : 2'd0));
  endfunction

  // Called at a negedge; returns at the negedge after the last payload word is taken.
  task automatic drive_pkt(input logic [31:0] dest, input int len, input logic [1:0] emp,
                           input int gap_pct, input int hold_at, input int hold_n);
    int i;
    int budget;
    int held;
    budget = 0;
    held   = 0;
    cmd_valid = 1'b1;
    cmd_dest  = dest;
    cmd_len   = LEN_W'(len);
    cmd_empty = emp;
    #1;
    while (!cmd_ready && budget < 400) begin
      @(negedge clk_clk);
      #1;
      budget++;
    end
    total++;
    if (!cmd_ready) begin
      bad++;
      $display("FAIL cmd_accept timeout: cmd_ready=%0b want 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk_clk);
    cmd_valid = 1'b0;
    i = 0;
    while (i < len && budget < 800) begin
      if (i == hold_at && held < hold_n) begin
        payload_valid = 1'b0;
        held++;
      end else begin
        payload_valid = ($urandom_range(99) >= gap_pct);
      end
      payload_data = pl[i];
      #1;
      if (payload_valid && payload_ready) i++;
      @(negedge clk_clk);
      budget++;
    end
    payload_valid = 1'b0;
    total++;
    if (i < len) begin
      bad++;
      $display("FAIL payload_accept timeout: accepted %0d want %0d", i, len);
    end
  endtask

  task automatic wait_beats(input int n);
    int b;
    b = 0;
    while (got_q.size() < n && b < 400) begin
      @(negedge clk_clk);
      b++;
    end
  endtask

  task automatic do_reset();
    reset_reset_n     = 1'b0;
    cmd_valid         = 1'b0;
    payload_valid     = 1'b0;
    output_here_ready = 1'b1;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_reset_n     = 1'b0;
    cmd_valid         = 1'b0;
    cmd_dest          = 32'd0;
    cmd_len           = '0;
    cmd_empty         = 2'd0;
    payload_valid     = 1'b0;
    payload_data      = 32'd0;
    output_here_ready = 1'b1;
    address_address   = 32'd5;
    @(negedge clk_clk);
    #1;
    total++;
    if ({output_here_valid, output_here_startofpacket, output_here_endofpacket} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got %b want 000", {output_here_valid,
               output_here_startofpacket, output_here_endofpacket});
    end
    total++;
    if ({output_here_data, output_here_empty} !== 34'd0) begin
      bad++;
      $display("FAIL reset_data got %h/%0d want 0/0", output_here_data, output_here_empty);
    end
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_cmd_ready_in_reset got %b want 0", cmd_ready);
    end
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || payload_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got cmd=%b pay=%b want 1 0", cmd_ready, payload_ready);
    end
`ifdef DIRCC_TX_PKT_COUNT_EN
    total++;
    if (tx_pkt_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_count got %0d want 0", tx_pkt_count);
    end
`endif
  endtask

  task automatic test_zero_len();
    int base;
    @(negedge clk_clk);
    address_address   = 32'h0000_0005;
    output_here_ready = 1'b1;
    base = got_q.size();
    exp_q.delete();
    exp_q.push_back(mk(32'h0000_0012, 1'b1, 1'b0, 2'd0));
    exp_q.push_back(mk(32'h0005_0000, 1'b0, 1'b1, 2'd0));
    drive_pkt(32'h0000_0012, 0, 2'd0, 0, -1, 0);
    @(negedge clk_clk);
    #1;
    total++;
    if (!(output_here_valid && output_here_endofpacket) || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_len_cmd_ready got valid=%b eop=%b cmd_ready=%b want 1 1 1",
               output_here_valid, output_here_endofpacket, cmd_ready);
    end
    wait_beats(base + exp_q.size());
    total++;
    if (got_q.size() !== base + exp_q.size()) begin
      bad++;
      $display("FAIL zero_len_count got %0d want %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      total++;
      if (got_q[base+i] !== exp_q[i]) begin
        bad++;
        $display("FAIL zero_len_beat%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_three_word();
    int base;
    @(negedge clk_clk);
    output_here_ready = 1'b1;
    pl[0] = 32'hA;
    pl[1] = 32'hB;
    pl[2] = 32'hC;
    base = got_q.size();
    exp_q.delete();
    model_pkt(32'h0000_0021, 3, 2'd2);
    drive_pkt(32'h0000_0021, 3, 2'd2, 0, -1, 0);
    wait_beats(base + exp_q.size());
    total++;
    if (got_q.size() !== base + exp_q.size()) begin
      bad++;
      $display("FAIL three_word_count got %0d want %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      total++;
      if (got_q[base+i] !== exp_q[i]) begin
        bad++;
        $display("FAIL three_word_beat%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      end
    end
    total++;
    if (got_q.size() >= base + 5 && got_cyc[base+4] - got_cyc[base] !== 4) begin
      bad++;
      $display("FAIL three_word_span got %0d want 4", got_cyc[base+4] - got_cyc[base]);
    end
  endtask

  task automatic test_backpressure();
    int base;
    @(negedge clk_clk);
    output_here_ready = 1'b1;
    address_address   = 32'h0000_0005;
    for (int k = 0; k < 4; k++) pl[k] = 32'hB000_0000 + k;
    base = got_q.size();
    exp_q.delete();
    model_pkt(32'h0000_0077, 4, 2'd1);
    fork
      drive_pkt(32'h0000_0077, 4, 2'd1, 0, -1, 0);
      begin
        int    w;
        beat_t snap;
        w = 0;
        while (!(output_here_valid && output_here_data == pl[1]) && w < 100) begin
          @(negedge clk_clk);
          w++;
        end
        total++;
        if (w >= 100) begin
          bad++;
          $display("FAIL stall_find got no second payload beat want data %h", pl[1]);
        end
        output_here_ready = 1'b0;
        snap = mk(output_here_data, output_here_startofpacket, output_here_endofpacket,
                  output_here_empty);
        for (int s = 0; s < 4; s++) begin
          #1;
          total++;
          if (payload_ready !== 1'b0 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready%0d got pay=%b cmd=%b want 0 0", s, payload_ready,
                     cmd_ready);
          end
          total++;
          if (output_here_valid !== 1'b1 || mk(output_here_data, output_here_startofpacket,
              output_here_endofpacket, output_here_empty) !== snap) begin
            bad++;
            $display("FAIL stall_hold%0d got %b/%h want 1/%h", s, output_here_valid,
                     output_here_data, snap);
          end
          @(negedge clk_clk);
        end
        output_here_ready = 1'b1;
      end
    join
    wait_beats(base + exp_q.size());
    total++;
    if (got_q.size() !== base + exp_q.size()) begin
      bad++;
      $display("FAIL stall_count got %0d want %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      total++;
      if (got_q[base+i] !== exp_q[i]) begin
        bad++;
        $display("FAIL stall_beat%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_starvation();
    int base;
    int e0;
    int bub;
    @(negedge clk_clk);
    output_here_ready = 1'b1;
    for (int k = 0; k < 5; k++) pl[k] = $urandom();
    base = got_q.size();
    e0   = eops;
    bub  = 0;
    exp_q.delete();
    model_pkt(32'h0000_0033, 5, 2'd3);
    fork
      drive_pkt(32'h0000_0033, 5, 2'd3, 0, 2, 2);
      begin
        int w;
        bit in_pkt;
        bit fin;
        w      = 0;
        in_pkt = 1'b0;
        fin    = 1'b0;
        while (!fin && w < 200) begin
          if (output_here_valid && output_here_startofpacket) in_pkt = 1'b1;
          else if (in_pkt && !output_here_valid) bub++;
          if (in_pkt && output_here_valid && output_here_endofpacket) fin = 1'b1;
          @(negedge clk_clk);
          w++;
        end
      end
    join
    wait_beats(base + exp_q.size());
    total++;
    if (bub !== 2) begin
      bad++;
      $display("FAIL starve_bubbles got %0d want 2", bub);
    end
    total++;
    if (eops - e0 !== 1) begin
      bad++;
      $display("FAIL starve_eops got %0d want 1", eops - e0);
    end
    total++;
    if (got_q.size() !== base + exp_q.size()) begin
      bad++;
      $display("FAIL starve_count got %0d want %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      total++;
      if (got_q[base+i] !== exp_q[i]) begin
        bad++;
        $display("FAIL starve_beat%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    @(negedge clk_clk);
    do_reset();
    base = got_q.size();
    exp_q.delete();
    pl[0] = 32'h1111_0001;
    model_pkt(32'h0000_0041, 1, 2'd1);
    drive_pkt(32'h0000_0041, 1, 2'd1, 0, -1, 0);
    pl[0] = 32'h2222_0001;
    pl[1] = 32'h2222_0002;
    model_pkt(32'h0000_0042, 2, 2'd3);
    drive_pkt(32'h0000_0042, 2, 2'd3, 0, -1, 0);
    wait_beats(base + exp_q.size());
    total++;
    if (got_q.size() !== base + exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count got %0d want %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      total++;
      if (got_q[base+i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_beat%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      end
    end
    total++;
    if (got_q.size() >= base + 7 && got_cyc[base+6] - got_cyc[base] !== 6) begin
      bad++;
      $display("FAIL b2b_span got %0d want 6", got_cyc[base+6] - got_cyc[base]);
    end
    total++;
    if (eops !== 2) begin
      bad++;
      $display("FAIL b2b_eops got %0d want 2", eops);
    end
`ifdef DIRCC_TX_PKT_COUNT_EN
    total++;
    if (tx_pkt_count !== 32'd2) begin
      bad++;
      $display("FAIL b2b_pkt_count got %0d want 2", tx_pkt_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int base;
    @(negedge clk_clk);
    output_here_ready = 1'b1;
    pl[0]     = 32'hDEAD_0000;
    cmd_valid = 1'b1;
    cmd_dest  = 32'h0000_0055;
    cmd_len   = LEN_W'(4);
    cmd_empty = 2'd0;
    @(negedge clk_clk);
    cmd_valid     = 1'b0;
    payload_valid = 1'b1;
    payload_data  = pl[0];
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b0;
    payload_valid = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    #1;
    total++;
    if ({output_here_valid, output_here_startofpacket, output_here_endofpacket} !== 3'b000) begin
      bad++;
      $display("FAIL midreset_flags got %b want 000", {output_here_valid,
               output_here_startofpacket, output_here_endofpacket});
    end
    total++;
    if (cmd_ready !== 1'b1 || payload_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_ready got cmd=%b pay=%b want 1 0", cmd_ready, payload_ready);
    end
`ifdef DIRCC_TX_PKT_COUNT_EN
    total++;
    if (tx_pkt_count !== 32'd0) begin
      bad++;
      $display("FAIL midreset_count got %0d want 0", tx_pkt_count);
    end
`endif
    @(negedge clk_clk);
    base = got_q.size();
    exp_q.delete();
    pl[0] = 32'hC0DE_0001;
    model_pkt(32'h0000_0066, 1, 2'd2);
    drive_pkt(32'h0000_0066, 1, 2'd2, 0, -1, 0);
    wait_beats(base + exp_q.size());
    total++;
    if (got_q.size() !== base + exp_q.size()) begin
      bad++;
      $display("FAIL midreset_pkt_count got %0d want %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      total++;
      if (got_q[base+i] !== exp_q[i]) begin
        bad++;
        $display("FAIL midreset_beat%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int          base;
    bit          done;
    int          len;
    logic [31:0] d;
    logic [1:0]  e;
    @(negedge clk_clk);
    address_address = $urandom();
    base = got_q.size();
    done = 1'b0;
    exp_q.delete();
    fork
      begin
        for (int p = 0; p < 24; p++) begin
          len = $urandom_range(8);
          d   = $urandom();
          e   = 2'($urandom_range(3));
          for (int k = 0; k < len; k++) pl[k] = $urandom();
          model_pkt(d, len, e);
          drive_pkt(d, len, e, 30, -1, 0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk_clk);
          output_here_ready = ($urandom_range(3) != 0);
        end
        output_here_ready = 1'b1;
      end
    join
    wait_beats(base + exp_q.size());
    total++;
    if (got_q.size() !== base + exp_q.size()) begin
      bad++;
      $display("FAIL random_count got %0d want %0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      total++;
      if (got_q[base+i] !== exp_q[i]) begin
        bad++;
        $display("FAIL random_beat%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_three_word();
    test_backpressure();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
